// File: rtl/spike_row_scheduler.sv
// Spike-gated three-lane synaptic row sequencer with saturating membrane accumulators.
// Optional build macro SPIKE_SKIP_EN: fetch only rows whose latched spike bit is set.
module spike_row_scheduler #(
   parameter int N_IN   = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_IN-1:0]   spikes,
   output logic              wt_rd_en,
   output logic [ADDR_W-1:0] wt_addr,
   input  logic [47:0]       wt_data,
   output logic              busy,
   output logic              done,
   output logic [47:0]       acc_out,
   output logic              acc_valid
);

   // state   | meaning
   // S_IDLE  | waiting for start; last result held on acc_out
   // S_FETCH | weight read issued for row_q
   // S_ACC   | wt_data valid; gate by spike bit and accumulate
   // S_DONE  | one-cycle done pulse, result becomes valid
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACC, S_DONE} state_t;

   state_t            state_q;
   logic [N_IN-1:0]   spk_q;
   logic [ADDR_W-1:0] row_q;
   logic [47:0]       acc_q, acc_d;
   logic              rd_en_q, busy_q, done_q, acc_valid_q;
   logic [ADDR_W-1:0] addr_q;

   logic              first_found, nxt_found;
   logic [ADDR_W-1:0] first_row, nxt_row;

   function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {a[15], a} + {b[15], b};
      // bits 16 and 15 disagree only when the 16-bit result overflowed
      if (s[16] != s[15]) sat16 = s[16] ? 16'h8000 : 16'h7FFF;
      else                sat16 = s[15:0];
   endfunction

   always_comb begin
      acc_d = acc_q;
      for (int l = 0; l < 3; l++) begin
         acc_d[16*l +: 16] = sat16(acc_q[16*l +: 16],
                                   spk_q[row_q] ? wt_data[16*l +: 16] : 16'd0);
      end
   end

`ifdef SPIKE_SKIP_EN
   // descending scan so the lowest qualifying index wins
   always_comb begin
      first_found = 1'b0;
      first_row   = '0;
      nxt_found   = 1'b0;
      nxt_row     = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (spikes[i]) begin
            first_found = 1'b1;
            first_row   = ADDR_W'(i);
         end
         if (spk_q[i] && (i > int'(row_q))) begin
            nxt_found = 1'b1;
            nxt_row   = ADDR_W'(i);
         end
      end
   end
`else
   assign first_found = 1'b1;
   assign first_row   = '0;
   assign nxt_found   = (row_q != ADDR_W'(N_IN - 1));
   assign nxt_row     = row_q + 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         spk_q       <= '0;
         row_q       <= '0;
         acc_q       <= '0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         acc_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  spk_q       <= spikes;
                  acc_q       <= '0;
                  acc_valid_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (first_found) begin
                     state_q <= S_FETCH;
                     row_q   <= first_row;
                     rd_en_q <= 1'b1;
                     addr_q  <= first_row;
                  end else begin
                     state_q <= S_DONE;
                     row_q   <= '0;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               state_q <= S_ACC;
               rd_en_q <= 1'b0;
               addr_q  <= '0;
            end
            S_ACC: begin
               acc_q <= acc_d;
               if (nxt_found) begin
                  state_q <= S_FETCH;
                  row_q   <= nxt_row;
                  rd_en_q <= 1'b1;
                  addr_q  <= nxt_row;
               end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               acc_valid_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wt_rd_en  = rd_en_q;
   assign wt_addr   = addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign acc_out   = acc_q;
   assign acc_valid = acc_valid_q;

endmodule

// File: tb/tb_spike_row_scheduler.sv
// Scoreboard bench for spike_row_scheduler: driver queues expected results, monitor checks them.
module tb_spike_row_scheduler;
   localparam int N_IN   = 8;
   localparam int ADDR_W = 3;
`ifdef SPIKE_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   localparam logic [47:0] W0    = {16'd100, 16'hFFFB, 16'd7};
   localparam logic [47:0] W2    = {16'd1, 16'd1, 16'd1};
   localparam logic [47:0] W9    = {16'd9, 16'd9, 16'd9};
   localparam logic [47:0] WS    = {16'd30000, 16'h8AD0, 16'd1};
   localparam logic [47:0] BASIC = {16'd101, 16'hFFFC, 16'd8};
   localparam logic [47:0] SATR  = {16'h7FFF, 16'h8000, 16'd8};
   localparam logic [47:0] ONES  = {16'd1, 16'd1, 16'd1};

   logic              clk = 1'b0;
   logic              rst, start;
   logic [N_IN-1:0]   spikes;
   logic              wt_rd_en;
   logic [ADDR_W-1:0] wt_addr;
   logic [47:0]       wt_data = '0;
   logic              busy, done, acc_valid;
   logic [47:0]       acc_out;

   spike_row_scheduler #(.N_IN(N_IN), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .spikes(spikes),
      .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data),
      .busy(busy), .done(done), .acc_out(acc_out), .acc_valid(acc_valid)
   );

   always #5 clk = ~clk;

   int ec = 0;
   always @(posedge clk) ec <= ec + 1;

   logic [47:0] mem [N_IN];
   // off-read cycles return junk so any use of wt_data outside ACC shows up
   always @(posedge clk) wt_data <= wt_rd_en ? mem[wt_addr] : 48'hBAD0_BAD0_BAD0;

   typedef struct {
      logic [47:0] acc;
      int          cyc;
      int          s0;
   } exp_t;

   exp_t sb[$];
   int   exp_addr[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   chk_after = 1'b0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_after) begin
            chk_after = 1'b0;
            chk("acc_valid_after_done", 48'(acc_valid), 48'd1);
            chk("busy_after_done", 48'(busy), 48'd0);
         end
         if (wt_rd_en) begin
            if (exp_addr.size() == 0) chk("unexpected_read", 48'd1, 48'd0);
            else                      chk("rd_addr", 48'(wt_addr), 48'(exp_addr.pop_front()));
         end else if (wt_addr != '0) begin
            chk("idle_addr_zero", 48'(wt_addr), 48'd0);
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 48'd1, 48'd0);
            end else begin
               e = sb.pop_front();
               chk("acc_out", acc_out, e.acc);
               chk("done_cycle", 48'(ec - e.s0), 48'(e.cyc));
               chk("reads_outstanding", 48'(exp_addr.size()), 48'd0);
               chk_after = 1'b1;
            end
         end
      end
   end

   task automatic set_mem(input logic [47:0] dflt);
      for (int i = 0; i < N_IN; i++) mem[i] = dflt;
   endtask

   task automatic set_mem_basic();
      set_mem(W9);
      mem[0] = W0;
      mem[2] = W2;
   endtask

   task automatic push_all();
      for (int i = 0; i < N_IN; i++) exp_addr.push_back(i);
   endtask

   // leaves the caller at the negedge of cycle 1
   task automatic start_pass(input logic [N_IN-1:0] spk, input logic [47:0] acc,
                             input int cyc, input bit expect_done);
      exp_t e;
      @(negedge clk);
      spikes = spk;
      start  = 1'b1;
      if (expect_done) begin
         e.acc = acc; e.cyc = cyc; e.s0 = ec;
         sb.push_back(e);
      end
      @(negedge clk);
      start  = 1'b0;
      spikes = '1 ^ spk;
      chk("busy_cycle1", 48'(busy), 48'd1);
      chk("acc_valid_low_cycle1", 48'(acc_valid), 48'd0);
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 100; k++) begin
         if (done) break;
         @(negedge clk);
      end
      if (k == 100) chk("done_timeout", 48'd1, 48'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; spikes = '0;
      set_mem_basic();
      repeat (3) @(negedge clk);
      chk("rst_busy", 48'(busy), 48'd0);
      chk("rst_done", 48'(done), 48'd0);
      chk("rst_rd_en", 48'(wt_rd_en), 48'd0);
      chk("rst_addr", 48'(wt_addr), 48'd0);
      chk("rst_acc_out", acc_out, 48'd0);
      chk("rst_acc_valid", 48'(acc_valid), 48'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic pass
      if (SKIP) begin exp_addr.push_back(0); exp_addr.push_back(2); end
      else push_all();
      start_pass(8'b0000_0101, BASIC, SKIP ? 5 : 17, 1'b1);
      wait_done();

      // saturation
      set_mem(WS);
      push_all();
      start_pass(8'hFF, SATR, 17, 1'b1);
      wait_done();

      // all-zero spikes
      set_mem_basic();
      if (!SKIP) push_all();
      start_pass(8'h00, 48'd0, SKIP ? 1 : 17, 1'b1);
      wait_done();

      // start while busy is ignored, then back-to-back start clears accumulators
      if (SKIP) begin exp_addr.push_back(0); exp_addr.push_back(2); end
      else push_all();
      start_pass(8'b0000_0101, BASIC, SKIP ? 5 : 17, 1'b1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; spikes = 8'hFF;
      @(negedge clk);
      start = 1'b0; spikes = '0;
      wait_done();
      if (SKIP) exp_addr.push_back(2);
      else push_all();
      start_pass(8'b0000_0100, ONES, SKIP ? 3 : 17, 1'b1);
      wait_done();

      // reset in cycle 4 aborts the pass
      exp_addr.push_back(0); exp_addr.push_back(1);
      start_pass(8'hFF, 48'd0, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 48'(busy), 48'd0);
      chk("abort_done", 48'(done), 48'd0);
      chk("abort_rd_en", 48'(wt_rd_en), 48'd0);
      chk("abort_acc_out", acc_out, 48'd0);
      chk("abort_acc_valid", 48'(acc_valid), 48'd0);
      chk("abort_reads_outstanding", 48'(exp_addr.size()), 48'd0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", 48'(done), 48'd0);

      // normal pass after abort
      if (SKIP) begin exp_addr.push_back(0); exp_addr.push_back(2); end
      else push_all();
      start_pass(8'b0000_0101, BASIC, SKIP ? 5 : 17, 1'b1);
      wait_done();

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 48'(sb.size()), 48'd0);
      chk("final_acc_valid", 48'(acc_valid), 48'd1);
      chk("final_acc_hold", acc_out, BASIC);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
